sensor_acq_responder: RTL and testbench



---
 rtl/sensor_acq_pkg.sv | 17 +
 rtl/sensor_acq_responder_if.sv | 32 +++
 rtl/acq_counter.sv | 28 ++
 rtl/sensor_acq_responder.sv | 117 +++++++++++
 tb/tb_sensor_acq_responder.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_acq_pkg.sv
// Shared types and constants for the sensor acquisition responder.
package sensor_acq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StStart,
        StWait,
        StDone
    } acq_state_t;

    localparam logic [7:0]  OVR_MAX       = 8'hFF;
    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_DELAY_W   = 16;
    localparam int unsigned DEF_TMO_W     = 16;

endpackage

// File: rtl/sensor_acq_responder_if.sv
// Timing-manager and sensor-core signals seen by one acquisition responder.
interface sensor_acq_responder_if
    import sensor_acq_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DELAY_W = DEF_DELAY_W,
    parameter int unsigned TMO_W   = DEF_TMO_W
);
    logic               trigger;
    logic               enable;
    logic [DELAY_W-1:0] start_delay;
    logic [TMO_W-1:0]   timeout_limit;
    logic               sensor_start;
    logic               sensor_valid;
    logic [DATA_W-1:0]  sensor_data;
    logic               done;
    logic [DATA_W-1:0]  data;
    logic               timeout;
    logic               busy;
    logic [7:0]         overrun_count;

    modport master (
        output trigger, enable, start_delay, timeout_limit, sensor_valid, sensor_data,
        input  sensor_start, done, data, timeout, busy, overrun_count
    );

    modport slave (
        input  trigger, enable, start_delay, timeout_limit, sensor_valid, sensor_data,
        output sensor_start, done, data, timeout, busy, overrun_count
    );

endinterface

// File: rtl/acq_counter.sv
// Loadable up/down counter; o_tc flags when the count equals i_tc_val.
module acq_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_up,
    input  logic [W-1:0] i_tc_val,
    output logic         o_tc
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= i_up ? r_count + 1'b1 : r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == i_tc_val);

endmodule

// File: rtl/sensor_acq_responder.sv
// Sequences one sensor acquisition per trigger: delay, start pulse, bounded wait, capture.
module sensor_acq_responder
    import sensor_acq_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DELAY_W = DEF_DELAY_W,
    parameter int unsigned TMO_W   = DEF_TMO_W
) (
    input logic                   clk,
    input logic                   rst,
    sensor_acq_responder_if.slave bus
);
    acq_state_t        r_state;
    acq_state_t        w_state_d;
    logic [TMO_W-1:0]  r_tmo_limit;
    logic [DATA_W-1:0] r_data;
    logic              r_timeout;
    logic [7:0]        r_ovr;

    logic w_accept, w_busy;
    logic w_dly_load, w_dly_en, w_dly_tc;
    logic w_tmo_load, w_tmo_en, w_tmo_tc;
    logic w_capture, w_expire;

    assign w_accept = bus.trigger & bus.enable;
    assign w_busy   = (r_state == StDelay) || (r_state == StStart) || (r_state == StWait);

    always_comb begin
        w_state_d  = r_state;
        w_dly_load = 1'b0;
        w_dly_en   = 1'b0;
        w_tmo_load = 1'b0;
        w_tmo_en   = 1'b0;
        w_capture  = 1'b0;
        w_expire   = 1'b0;
        if (r_state != StIdle && !bus.enable) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_accept) begin
                        w_dly_load = 1'b1;
                        w_state_d  = (bus.start_delay == '0) ? StStart : StDelay;
                    end
                end
                StDelay: begin
                    if (w_dly_tc) w_state_d = StStart;
                    else          w_dly_en  = 1'b1;
                end
                StStart: begin
                    w_tmo_load = 1'b1;
                    w_state_d  = StWait;
                end
                StWait: begin
                    // Valid takes priority over a timeout expiring on the same edge.
                    if (bus.sensor_valid) begin
                        w_capture = 1'b1;
                        w_state_d = StDone;
                    end else if (r_tmo_limit != '0 && w_tmo_tc) begin
                        w_expire  = 1'b1;
                        w_state_d = StDone;
                    end else begin
                        w_tmo_en  = 1'b1;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_tmo_limit <= '0;
            r_data      <= '0;
            r_timeout   <= 1'b0;
            r_ovr       <= 8'd0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StStart) r_tmo_limit <= bus.timeout_limit;
            if (w_capture)          r_data      <= bus.sensor_data;
            // Timeout flag lives only while DONE; any exit from DONE clears it.
            r_timeout <= (w_state_d == StDone) && (w_expire || r_timeout);
            if (bus.trigger && w_busy && r_ovr != OVR_MAX) r_ovr <= r_ovr + 1'b1;
        end
    end

    acq_counter #(.W(DELAY_W)) u_dly_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_dly_load),
        .i_load_val (bus.start_delay),
        .i_en       (w_dly_en),
        .i_up       (1'b0),
        .i_tc_val   (DELAY_W'(1)),
        .o_tc       (w_dly_tc)
    );

    acq_counter #(.W(TMO_W)) u_tmo_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmo_load),
        .i_load_val ('0),
        .i_en       (w_tmo_en),
        .i_up       (1'b1),
        .i_tc_val   (r_tmo_limit),
        .o_tc       (w_tmo_tc)
    );

    assign bus.sensor_start  = (r_state == StStart);
    assign bus.done          = (r_state == StDone);
    assign bus.busy          = w_busy;
    assign bus.data          = r_data;
    assign bus.timeout       = r_timeout;
    assign bus.overrun_count = r_ovr;

endmodule

// File: tb/tb_sensor_acq_responder.sv
// Randomized scoreboard bench for sensor_acq_responder.
module tb_sensor_acq_responder;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        tmo;
    } exp_done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int          exp_start_q[$];
    exp_done_t   exp_done_q[$];
    logic [15:0] m_data = 16'h0;
    int          m_ovr  = 0;

    logic        prev_done = 1'b0;
    int          mon_s;
    exp_done_t   mon_d;

    sensor_acq_responder_if #(.DATA_W(16), .DELAY_W(16), .TMO_W(16)) bus ();

    sensor_acq_responder #(.DATA_W(16), .DELAY_W(16), .TMO_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: every start pulse and every rising done is checked against the queues.
    always @(negedge clk) begin
        if (bus.sensor_start === 1'b1) begin
            checks++;
            if (exp_start_q.size() == 0) begin
                errors++;
                $display("FAIL start_pulse: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_s = exp_start_q.pop_front();
                if (cyc != mon_s) begin
                    errors++;
                    $display("FAIL start_cycle: got %0d expected %0d", cyc, mon_s);
                end
            end
        end
        if (bus.done === 1'b1 && prev_done !== 1'b1) begin
            checks++;
            if (exp_done_q.size() == 0) begin
                errors++;
                $display("FAIL done_rise: got done at cycle %0d, expected none", cyc);
            end else begin
                mon_d = exp_done_q.pop_front();
                if (cyc != mon_d.cyc || bus.data !== mon_d.data || bus.timeout !== mon_d.tmo) begin
                    errors++;
                    $display("FAIL done_result: got cyc %0d data %h tmo %b expected cyc %0d data %h tmo %b",
                             cyc, bus.data, bus.timeout, mon_d.cyc, mon_d.data, mon_d.tmo);
                end
            end
        end
        prev_done = bus.done;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference model: start at E0+D, WAIT edges begin at S=E0+D+1; valid at S+k wins while
    // k <= L+1 (or L==0), otherwise timeout lands at S+L+1 with data unchanged.
    task automatic push_expect(input int e0, input int d, input int l, input int k,
                               input logic [15:0] val);
        int s;
        s = e0 + d + 1;
        exp_start_q.push_back(e0 + d);
        if (k != 0 && (l == 0 || k <= l + 1)) begin
            exp_done_q.push_back('{s + k, val, 1'b0});
            m_data = val;
        end else begin
            exp_done_q.push_back('{s + l + 1, m_data, 1'b1});
        end
    endtask

    task automatic wait_start(input int bound);
        int t;
        t = 0;
        while (bus.sensor_start !== 1'b1 && t < bound) begin
            @(negedge clk);
            t++;
        end
        bus.trigger      = 1'b0;
        bus.sensor_valid = 1'b0;
        if (bus.sensor_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL start_wait: got no sensor_start, expected one within %0d cycles", bound);
        end
    endtask

    // Called at the negedge where sensor_start is visible.
    task automatic respond(input int k, input logic [15:0] val);
        @(negedge clk);
        bus.timeout_limit = 16'($urandom);
        if (k != 0) begin
            repeat (k - 1) @(negedge clk);
            bus.sensor_valid = 1'b1;
            bus.sensor_data  = val;
            @(negedge clk);
            bus.sensor_valid = 1'b0;
            bus.sensor_data  = 16'($urandom);
        end
    endtask

    task automatic wait_done(input int bound);
        int t;
        t = 0;
        while (bus.done !== 1'b1 && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got done=%b, expected 1 within %0d cycles", bus.done, bound);
        end
    endtask

    // One acquisition; g>0 adds an overrun trigger g edges after the accepted one (g <= d).
    task automatic acquire(input int d, input int l, input int k, input logic [15:0] val,
                           input int g);
        int e0, t;
        @(negedge clk);
        bus.start_delay   = 16'(d);
        bus.timeout_limit = 16'(l);
        bus.trigger       = 1'b1;
        e0 = cyc + 1;
        push_expect(e0, d, l, k, val);
        if (g > 0 && m_ovr < 255) m_ovr++;
        @(negedge clk);
        t = 0;
        while (bus.sensor_start !== 1'b1 && t <= d + 3) begin
            bus.trigger      = (g > 0 && t == g - 1);
            bus.sensor_valid = (t == 0 && d >= 2);
            bus.sensor_data  = 16'($urandom);
            bus.start_delay  = 16'($urandom);
            @(negedge clk);
            t++;
        end
        wait_start(1);
        respond(k, val);
        wait_done(l + k + 10);
        chk("overrun_count", 32'(bus.overrun_count), 32'(m_ovr));
    endtask

    task automatic abort_wait();
        @(negedge clk);
        bus.start_delay   = 16'd1;
        bus.timeout_limit = 16'd0;
        bus.trigger       = 1'b1;
        exp_start_q.push_back(cyc + 2);
        @(negedge clk);
        bus.trigger = 1'b0;
        wait_start(6);
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_timeout", 32'(bus.timeout), 32'd0);
        bus.enable       = 1'b1;
        bus.sensor_valid = 1'b1;
        bus.sensor_data  = ~m_data;
        @(negedge clk);
        bus.sensor_valid = 1'b0;
        chk("late_valid_done", 32'(bus.done), 32'd0);
        chk("late_valid_data", 32'(bus.data), 32'(m_data));
        bus.enable  = 1'b0;
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        bus.enable  = 1'b1;
        repeat (3) @(negedge clk);
        chk("disabled_trigger_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic saturate();
        int e0;
        logic [15:0] val;
        val = 16'($urandom);
        @(negedge clk);
        bus.start_delay   = 16'd700;
        bus.timeout_limit = 16'd0;
        bus.trigger       = 1'b1;
        e0 = cyc + 1;
        push_expect(e0, 700, 0, 1, val);
        @(negedge clk);
        bus.trigger = 1'b0;
        repeat (300) begin
            @(negedge clk);
            bus.trigger = 1'b1;
            @(negedge clk);
            bus.trigger = 1'b0;
        end
        m_ovr = (m_ovr + 300 > 255) ? 255 : m_ovr + 300;
        chk("overrun_saturated", 32'(bus.overrun_count), 32'(m_ovr));
        wait_start(150);
        respond(1, val);
        wait_done(10);
    endtask

    task automatic reset_in_delay();
        @(negedge clk);
        bus.start_delay = 16'd8;
        bus.trigger     = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        m_data = 16'h0;
        m_ovr  = 0;
        chk("rst_start", 32'(bus.sensor_start), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_data", 32'(bus.data), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overrun", 32'(bus.overrun_count), 32'd0);
        repeat (12) @(negedge clk);
        chk("post_reset_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int d, l, k, g;
        bus.trigger       = 1'b0;
        bus.enable        = 1'b1;
        bus.start_delay   = 16'd0;
        bus.timeout_limit = 16'd0;
        bus.sensor_valid  = 1'b0;
        bus.sensor_data   = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_start", 32'(bus.sensor_start), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_data", 32'(bus.data), 32'd0);
        chk("reset_timeout", 32'(bus.timeout), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_overrun", 32'(bus.overrun_count), 32'd0);

        acquire(3, 0, 5, 16'hA5A5, 0);
        acquire(0, 10, 0, 16'h1234, 0);
        chk("timeout_keeps_data", 32'(bus.data), 32'hA5A5);
        acquire(5, 0, 2, 16'h5A5A, 2);
        acquire(2, 4, 5, 16'hC3C3, 0);
        abort_wait();
        acquire(1, 3, 2, 16'h0F0F, 0);

        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(6, 0));
            l = int'($urandom_range(8, 0));
            k = (l == 0) ? int'($urandom_range(6, 1)) : int'($urandom_range(l + 3, 0));
            g = (d > 0 && $urandom_range(1, 0) == 1) ? int'($urandom_range(d, 1)) : 0;
            acquire(d, l, k, 16'($urandom), g);
        end

        saturate();
        reset_in_delay();
        acquire(2, 0, 3, 16'hBEEF, 0);

        repeat (5) @(negedge clk);
        chk("start_queue_drained", 32'(exp_start_q.size()), 32'd0);
        chk("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
